// File: rtl/exc_pkg.sv
// Shared cause codes, pending/mask bit positions and sequencer state encoding.
package exc_pkg;

  localparam logic [2:0] CAUSE_NONE = 3'd0;
  localparam logic [2:0] CAUSE_OVF  = 3'd1;
  localparam logic [2:0] CAUSE_STEP = 3'd2;
  localparam logic [2:0] CAUSE_BRK  = 3'd3;
  localparam logic [2:0] CAUSE_EXT  = 3'd4;

  // Bit positions within pending and mask: {ext, step, ovf, brk}
  localparam int unsigned BIT_BRK  = 0;
  localparam int unsigned BIT_OVF  = 1;
  localparam int unsigned BIT_STEP = 2;
  localparam int unsigned BIT_EXT  = 3;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    VECTOR,
    SERVICE
  } state_t;

endpackage

// File: rtl/exception_sequencer_if.sv
// Pipeline-side bundle: exception sources in, flush/redirect/EPC state out.
interface exception_sequencer_if #(
  parameter int EPC_W = 32
);
  logic             overflow;
  logic             instr_break;
  logic             ext_irq;
  logic             single_step_en;
  logic             instr_retire;
  logic             if_JR;
  logic [3:0]       mask;
  logic [EPC_W-1:0] cur_pc;
  logic             flush;
  logic             pc_redirect;
  logic [EPC_W-1:0] redirect_pc;
  logic [EPC_W-1:0] epc;
  logic [2:0]       cause;
  logic             in_service;

  // Pipeline / testbench side
  modport master (
    output overflow, instr_break, ext_irq, single_step_en, instr_retire,
           if_JR, mask, cur_pc,
    input  flush, pc_redirect, redirect_pc, epc, cause, in_service
  );

  // Exception sequencer side
  modport slave (
    input  overflow, instr_break, ext_irq, single_step_en, instr_retire,
           if_JR, mask, cur_pc,
    output flush, pc_redirect, redirect_pc, epc, cause, in_service
  );
endinterface

// File: rtl/exc_priority_sel.sv
// Fixed-priority pick over enabled pending sources: brk > ovf > step > ext.
module exc_priority_sel
  import exc_pkg::*;
(
  input  logic [3:0] pending,
  input  logic [3:0] mask,
  output logic [3:0] grant,
  output logic [2:0] cause
);

  logic [3:0] req;

  assign req = pending & mask;

  // One-hot grant and matching cause code for the highest-priority request
  always_comb begin
    grant = '0;
    cause = CAUSE_NONE;
    if (req[BIT_BRK]) begin
      grant[BIT_BRK] = 1'b1;
      cause          = CAUSE_BRK;
    end else if (req[BIT_OVF]) begin
      grant[BIT_OVF] = 1'b1;
      cause          = CAUSE_OVF;
    end else if (req[BIT_STEP]) begin
      grant[BIT_STEP] = 1'b1;
      cause           = CAUSE_STEP;
    end else if (req[BIT_EXT]) begin
      grant[BIT_EXT] = 1'b1;
      cause          = CAUSE_EXT;
    end
  end

endmodule

// File: rtl/exception_sequencer.sv
// Exception entry/exit sequencer: sticky pending sources, priority take,
// timed flush, one-cycle vector redirect, and no nesting until JR return.
module exception_sequencer
  import exc_pkg::*;
#(
  parameter logic [31:0] SERVICE_PC   = 32'd76,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int          EPC_W        = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  exception_sequencer_if.slave bus
);

  state_t           state;
  logic [2:0]       cnt;
  logic [3:0]       pending;
  logic [3:0]       set_bits;
  logic [3:0]       grant;
  logic [2:0]       sel_cause;
  logic             step_armed;
  logic             step_hit;
  logic             take;
  logic             jr_ret;
  logic             flush_q;
  logic             redirect_q;
  logic             in_service_q;
  logic [EPC_W-1:0] redirect_pc_q;
  logic [EPC_W-1:0] epc_q;
  logic [2:0]       cause_q;

  exc_priority_sel u_sel (
    .pending (pending),
    .mask    (bus.mask),
    .grant   (grant),
    .cause   (sel_cause)
  );

  assign step_hit = bus.instr_retire & step_armed;
  assign set_bits = {bus.ext_irq, step_hit, bus.overflow, bus.instr_break};
  assign take     = (state == IDLE) && (grant != '0);
  assign jr_ret   = (state == SERVICE) && bus.if_JR;

  // Sticky pending bits; the taken bit's clear wins over a same-cycle set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending | set_bits) & ~(take ? grant : 4'b0000);
  end

  // Step arming: loaded on handler return, consumed by the next retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        step_armed <= 1'b0;
    else if (jr_ret)   step_armed <= bus.single_step_en;
    else if (step_hit) step_armed <= 1'b0;
  end

  // Sequencer FSM with registered flush/redirect/service outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      flush_q       <= 1'b0;
      redirect_q    <= 1'b0;
      in_service_q  <= 1'b0;
      redirect_pc_q <= EPC_W'(SERVICE_PC);
      epc_q         <= '0;
      cause_q       <= CAUSE_NONE;
    end else begin
      redirect_pc_q <= EPC_W'(SERVICE_PC);
      case (state)
        IDLE: begin
          if (take) begin
            state        <= FLUSH;
            cnt          <= 3'(FLUSH_CYCLES - 1);
            epc_q        <= bus.cur_pc;
            cause_q      <= sel_cause;
            flush_q      <= 1'b1;
            in_service_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (cnt == '0) begin
            state      <= VECTOR;
            redirect_q <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        VECTOR: begin
          state      <= SERVICE;
          flush_q    <= 1'b0;
          redirect_q <= 1'b0;
        end
        SERVICE: begin
          if (bus.if_JR) begin
            state        <= IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.flush       = flush_q;
  assign bus.pc_redirect = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.epc         = epc_q;
  assign bus.cause       = cause_q;
  assign bus.in_service  = in_service_q;

endmodule
